// File: rtl/ramp_sequencer.sv
// Object-counting run sequencer: synchronizes the control inputs and debounces the sensor.
// A run counts filtered sensor rising edges up to a latched target, then holds in DONE.
module ramp_sequencer #(
    parameter int DEBOUNCE_CYCLES = 2_500_000,
    parameter int MAX_COUNT       = 20
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       hold,
    input  logic       sensor,
    input  logic [4:0] target,
    output logic [4:0] count,
    output logic [1:0] state,
    output logic       done,
    output logic       buzzer_en
);

    localparam int             CW      = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0]  DB_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [4:0]     MAX_C   = 5'(MAX_COUNT);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        PAUSE = 2'b10,
        DONE  = 2'b11
    } state_t;

    logic [1:0]    start_sync_q, hold_sync_q, sensor_sync_q;
    logic          start_s, hold_s, sensor_s;
    logic [CW-1:0] db_cnt_q;
    logic          filt_q, filt_prev_q, obj_evt_q;
    state_t        state_q, state_d;
    logic [4:0]    count_q, count_d;
    logic [4:0]    eff_target_q, eff_target_d;
    logic          done_q, done_d;
    logic [4:0]    tgt_clamped;

    assign start_s  = start_sync_q[1];
    assign hold_s   = hold_sync_q[1];
    assign sensor_s = sensor_sync_q[1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            start_sync_q  <= '0;
            hold_sync_q   <= '0;
            sensor_sync_q <= '0;
        end else begin
            start_sync_q  <= {start_sync_q[0], start};
            hold_sync_q   <= {hold_sync_q[0], hold};
            sensor_sync_q <= {sensor_sync_q[0], sensor};
        end
    end

    // The object event is registered once more after the filtered edge compare,
    // so the count moves two edges after the filtered level changes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            db_cnt_q    <= '0;
            filt_q      <= 1'b0;
            filt_prev_q <= 1'b0;
            obj_evt_q   <= 1'b0;
        end else begin
            filt_prev_q <= filt_q;
            obj_evt_q   <= filt_q & ~filt_prev_q;
            if (sensor_s == filt_q) begin
                db_cnt_q <= '0;
            end else if (db_cnt_q == DB_LAST) begin
                filt_q   <= sensor_s;
                db_cnt_q <= '0;
            end else begin
                db_cnt_q <= db_cnt_q + CW'(1);
            end
        end
    end

    assign tgt_clamped = (target == 5'd0 || target > MAX_C) ? MAX_C : target;

    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        eff_target_d = eff_target_q;
        case (state_q)
            IDLE: begin
                count_d = 5'd0;
                if (start_s) begin
                    state_d      = RUN;
                    eff_target_d = tgt_clamped;
                end
            end
            RUN: begin
                if (hold_s) begin
                    state_d = PAUSE;
                end else if (obj_evt_q && count_q < eff_target_q) begin
                    count_d = count_q + 5'd1;
                    if (count_d == eff_target_q) state_d = DONE;
                end
            end
            PAUSE: begin
                if (!hold_s) state_d = RUN;
            end
            default: ;
        endcase
        // Dropping start aborts any run regardless of what else happened this cycle.
        if (state_q != IDLE && !start_s) begin
            state_d = IDLE;
            count_d = 5'd0;
        end
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            count_q      <= 5'd0;
            eff_target_q <= MAX_C;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            eff_target_q <= eff_target_d;
            done_q       <= done_d;
        end
    end

    assign count     = count_q;
    assign state     = state_q;
    assign done      = done_q;
    assign buzzer_en = done_q;

endmodule
